result_writeback: RTL and testbench
===================================

RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 SHALL have parameter number_of_clusters, default 40, number of clusters in the solution vector.
REQ-002 SHALL have parameter number_of_equations_per_cluster, default 19, equations per cluster.
REQ-003 SHALL have parameter element_width, default 32, bits per vector element.
REQ-004 SHALL have parameter no_of_units, default 8, lanes per ALU result beat.
REQ-005 SHALL have parameter memories_address_width, default 20, width of the memory word address.
REQ-006 SHALL have parameter base_address, default 0, memory word address of the first write.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port start, input, 1, one-cycle pulse that begins one vector writeback.
REQ-010 SHALL have port in_valid, input, 1, ALU result beat (memoryP_input/memoryR_input/memoryX_input) is valid.
REQ-011 SHALL have port in_data, input, no_of_units*element_width, ALU result beat; lane 0 in the LSBs.
REQ-012 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-013 SHALL have port mem_ready, input, 1, target memory accepts a write this cycle.
REQ-014 SHALL have port mem_we, output, 1, write request.
REQ-015 SHALL have port mem_addr, output, memories_address_width, write word address.
REQ-016 SHALL have port mem_wdata, output, no_of_units*element_width, write data.
REQ-017 SHALL have port mem_lane_en, output, no_of_units, per-lane write enable.
REQ-018 SHALL have port busy, output, 1, high in RUN.
REQ-019 SHALL have port finish, output, 1, one-cycle pulse after the last write completes.
REQ-020 SHALL have port words_written, output, 32, count of completed writes in the current run.

Function
REQ-021 SHALL derive TOTAL_ELEMS = number_of_clusters*number_of_equations_per_cluster, TOTAL_WORDS = ceil(TOTAL_ELEMS/no_of_units), LAST_LANES = TOTAL_ELEMS-(TOTAL_WORDS-1)*no_of_units (defaults: 760, 95, 8).
REQ-022 SHALL implement FSM IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE on the cycle the write with words_written==TOTAL_WORDS-1 completes (mem_we&&mem_ready); DONE->IDLE unconditionally after one cycle.
REQ-023 SHALL assert finish only in DONE and busy only in RUN.
REQ-024 SHALL ignore start outside IDLE; start in IDLE SHALL clear words_written and the accept counter.
REQ-025 SHALL buffer accepted beats in a 2-entry FIFO; a beat is accepted when in_valid&&in_ready.
REQ-026 SHALL drive in_ready = RUN && FIFO not full && accepted count < TOTAL_WORDS; no same-cycle bypass when full.
REQ-027 SHALL drive mem_we = FIFO not empty, with mem_wdata from the FIFO head; a beat accepted in cycle N is presented no earlier than cycle N+1.
REQ-028 SHALL pop the FIFO and increment words_written only when mem_we&&mem_ready; mem_addr/mem_wdata SHALL be held stable while mem_we&&!mem_ready.
REQ-029 SHALL drive mem_addr = base_address + words_written, truncated to memories_address_width (wrap-around modulo 2^memories_address_width).
REQ-030 SHALL drive mem_lane_en all-ones, except for word TOTAL_WORDS-1, where only the low LAST_LANES bits are set and mem_wdata lanes >= LAST_LANES are zero.
REQ-031 SHALL drop in_valid beats while in IDLE or DONE, or once TOTAL_WORDS beats have been accepted.

Reset
REQ-032 SHALL, while reset is high at a clock edge, go to IDLE, flush the FIFO, clear both counters, and drive in_ready, mem_we, mem_lane_en, busy, finish to 0 and mem_addr to base_address, including when reset occurs mid-RUN.

Structure
REQ-033 SHALL place the FSM state encoding and the TOTAL_ELEMS/TOTAL_WORDS/LAST_LANES derivations in a shared solver package.
REQ-034 SHALL instantiate the FIFO as sub-module result_fifo2 (depth 2, width no_of_units*element_width, push/pop/full/empty).

Verification
REQ-035 SHALL cover: defaults, start, 95 back-to-back beats, mem_ready=1 -> addresses 0..94, finish one cycle after the write at address 94, words_written=95.
REQ-036 SHALL cover: clusters=3, eq=5 (15 elems, 2 words) -> second write mem_lane_en=8'h7F, lane 7 data zero.
REQ-037 SHALL cover: mem_ready low for 5 cycles after two accepts -> in_ready=0, mem_addr/mem_wdata held, no beat lost.
REQ-038 SHALL cover: base_address=2^20-2, 4 words -> addresses FFFFE, FFFFF, 00000, 00001.
REQ-039 SHALL cover: reset asserted after 10 writes -> next cycle all outputs at reset values; new start restarts at base_address.
REQ-040 SHALL cover: in_valid in IDLE and a 96th beat -> both dropped, in_ready=0, no extra write.

Source files
------------

// File: rtl/result_writeback_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | result_writeback_pkg : FSM encoding and solution-vector size helpers |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package result_writeback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_t;

  function automatic int calc_total_elems(input int clusters, input int eqs);
    return clusters * eqs;
  endfunction

  function automatic int calc_total_words(input int elems, input int units);
    return (elems + units - 1) / units;
  endfunction

  // Number of populated lanes in the final (possibly partial) word.
  function automatic int calc_last_lanes(input int elems, input int units);
    return elems - (calc_total_words(elems, units) - 1) * units;
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | result_fifo2 : two-entry registered FIFO for ALU result beats        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module result_fifo2 #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_rdata = r_mem[r_rd_ptr];

  // Storage needs no reset: the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/result_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | result_writeback : streams ALU result beats into the solution memory |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int number_of_clusters              = 40,
  parameter int number_of_equations_per_cluster = 19,
  parameter int element_width                   = 32,
  parameter int no_of_units                     = 8,
  parameter int memories_address_width          = 20,
  parameter int base_address                    = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   in_valid,
  input  logic [no_of_units*element_width-1:0]   in_data,
  output logic                                   in_ready,
  input  logic                                   mem_ready,
  output logic                                   mem_we,
  output logic [memories_address_width-1:0]      mem_addr,
  output logic [no_of_units*element_width-1:0]   mem_wdata,
  output logic [no_of_units-1:0]                 mem_lane_en,
  output logic                                   busy,
  output logic                                   finish,
  output logic [31:0]                            words_written
);

  localparam int C_DATA_W      = no_of_units * element_width;
  localparam int C_TOTAL_ELEMS = calc_total_elems(number_of_clusters, number_of_equations_per_cluster);
  localparam int C_TOTAL_WORDS = calc_total_words(C_TOTAL_ELEMS, no_of_units);
  localparam int C_LAST_LANES  = calc_last_lanes(C_TOTAL_ELEMS, no_of_units);

  localparam logic [31:0] C_TOTAL_WORDS32 = 32'(C_TOTAL_WORDS);
  localparam logic [31:0] C_LAST_WORD32   = 32'(C_TOTAL_WORDS - 1);
  localparam logic [memories_address_width-1:0] C_BASE_ADDR =
    memories_address_width'(base_address);
  localparam logic [no_of_units-1:0] C_ALL_LANES  = '1;
  localparam logic [no_of_units-1:0] C_LAST_LANES_EN = C_ALL_LANES >> (no_of_units - C_LAST_LANES);

  wb_state_t          r_state;
  wb_state_t          w_state_nxt;
  logic [31:0]        r_words_written;
  logic [31:0]        r_accept_cnt;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_last_word;
  logic [C_DATA_W-1:0] w_fifo_head;
  logic [C_DATA_W-1:0] w_last_keep;

  result_fifo2 #(
    .WIDTH (C_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_wdata (in_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Lanes past the end of the vector are blanked on the final word.
  for (genvar l = 0; l < no_of_units; l++) begin : g_last_keep
    assign w_last_keep[l*element_width +: element_width] = {element_width{C_LAST_LANES_EN[l]}};
  end

  assign in_ready    = (r_state == ST_RUN) && !w_fifo_full && (r_accept_cnt < C_TOTAL_WORDS32);
  assign w_push      = in_valid && in_ready;
  assign mem_we      = !w_fifo_empty;
  assign w_pop       = mem_we && mem_ready;
  assign w_last_word = (r_words_written == C_LAST_WORD32);

  assign mem_addr    = C_BASE_ADDR + r_words_written[memories_address_width-1:0];
  assign mem_wdata   = w_last_word ? (w_fifo_head & w_last_keep) : w_fifo_head;
  assign mem_lane_en = !mem_we ? '0 : (w_last_word ? C_LAST_LANES_EN : C_ALL_LANES);

  assign busy          = (r_state == ST_RUN);
  assign finish        = (r_state == ST_DONE);
  assign words_written = r_words_written;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_pop && w_last_word) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_words_written <= 32'd0;
      r_accept_cnt    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && start) begin
        r_words_written <= 32'd0;
        r_accept_cnt    <= 32'd0;
      end else begin
        if (w_push) r_accept_cnt    <= r_accept_cnt + 32'd1;
        if (w_pop)  r_words_written <= r_words_written + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_result_writeback : randomized self-checking bench, three configs  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_result_writeback;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start_s     [3];
  logic         in_valid_s  [3];
  logic         mem_ready_s [3];
  logic         in_ready_s  [3];
  logic         mem_we_s    [3];
  logic         busy_s      [3];
  logic         finish_s    [3];
  logic [255:0] in_data_s   [3];
  logic [255:0] mem_wdata_s [3];
  logic [19:0]  mem_addr_s  [3];
  logic [7:0]   lane_s      [3];
  logic [31:0]  ww_s        [3];

  int n_tests = 0;
  int n_fail  = 0;

  int cfg_c    [3] = '{40, 3, 4};
  int cfg_e    [3] = '{19, 5, 8};
  int cfg_base [3] = '{0, 0, 1048574};

  result_writeback dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .in_data(in_data_s[0]), .in_ready(in_ready_s[0]), .mem_ready(mem_ready_s[0]),
    .mem_we(mem_we_s[0]), .mem_addr(mem_addr_s[0]), .mem_wdata(mem_wdata_s[0]),
    .mem_lane_en(lane_s[0]), .busy(busy_s[0]), .finish(finish_s[0]),
    .words_written(ww_s[0])
  );

  result_writeback #(
    .number_of_clusters(3), .number_of_equations_per_cluster(5)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .in_data(in_data_s[1]), .in_ready(in_ready_s[1]), .mem_ready(mem_ready_s[1]),
    .mem_we(mem_we_s[1]), .mem_addr(mem_addr_s[1]), .mem_wdata(mem_wdata_s[1]),
    .mem_lane_en(lane_s[1]), .busy(busy_s[1]), .finish(finish_s[1]),
    .words_written(ww_s[1])
  );

  result_writeback #(
    .number_of_clusters(4), .number_of_equations_per_cluster(8), .base_address(1048574)
  ) dut2 (
    .clk(clk), .reset(reset), .start(start_s[2]), .in_valid(in_valid_s[2]),
    .in_data(in_data_s[2]), .in_ready(in_ready_s[2]), .mem_ready(mem_ready_s[2]),
    .mem_we(mem_we_s[2]), .mem_addr(mem_addr_s[2]), .mem_wdata(mem_wdata_s[2]),
    .mem_lane_en(lane_s[2]), .busy(busy_s[2]), .finish(finish_s[2]),
    .words_written(ww_s[2])
  );

  task automatic chk(input int k, input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL dut%0d %s observed=%0h expected=%0h", k, tag, obs, exp);
    end
  endtask

  function automatic int tw_of(input int k);
    return (cfg_c[k] * cfg_e[k] + 7) / 8;
  endfunction

  function automatic int ll_of(input int k);
    return cfg_c[k] * cfg_e[k] - (tw_of(k) - 1) * 8;
  endfunction

  function automatic logic [19:0] exp_addr(input int k, input int i);
    return 20'((cfg_base[k] + i) % 1048576);
  endfunction

  function automatic logic [255:0] exp_data(input int k, input int i, input logic [255:0] beat);
    logic [255:0] d;
    d = beat;
    if (i == tw_of(k) - 1)
      for (int l = ll_of(k); l < 8; l++) d[l*32 +: 32] = 32'd0;
    return d;
  endfunction

  function automatic logic [7:0] exp_lanes(input int k, input int i);
    return (i == tw_of(k) - 1) ? 8'((1 << ll_of(k)) - 1) : 8'hFF;
  endfunction

  function automatic logic [255:0] rand_beat();
    logic [255:0] b;
    for (int l = 0; l < 8; l++) b[l*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic check_reset_vals(input int k);
    chk(k, "rst_in_ready", in_ready_s[k], 1'b0);
    chk(k, "rst_mem_we", mem_we_s[k], 1'b0);
    chk(k, "rst_lane_en", lane_s[k], 8'h00);
    chk(k, "rst_busy", busy_s[k], 1'b0);
    chk(k, "rst_finish", finish_s[k], 1'b0);
    chk(k, "rst_mem_addr", mem_addr_s[k], exp_addr(k, 0));
    chk(k, "rst_words_written", ww_s[k], 32'd0);
  endtask

  // One vector writeback; acc/wr are the model's accepted and written counts.
  task automatic run_vector(input int k, input int p_valid, input int p_ready,
                            input bit stall, input int abort_after);
    logic [255:0] beats[$];
    int  tw, acc, wr, idx, stall_left, cyc;
    bit  stall_done, fin_exp, done, aborting, exp_ready, exp_we;
    tw = tw_of(k);
    beats.delete();
    for (int i = 0; i < tw; i++) beats.push_back(rand_beat());
    acc = 0; wr = 0; idx = 0; stall_left = 0; cyc = 0;
    stall_done = 0; fin_exp = 0; done = 0; aborting = 0;

    in_valid_s[k] = 1'b1;
    in_data_s[k]  = beats[0];
    mem_ready_s[k] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk(k, "idle_in_ready", in_ready_s[k], 1'b0);
      chk(k, "idle_mem_we", mem_we_s[k], 1'b0);
      @(posedge clk); #1;
    end
    start_s[k] = 1'b1;
    @(negedge clk);
    chk(k, "pre_start_busy", busy_s[k], 1'b0);
    @(posedge clk); #1;
    start_s[k] = 1'b0;

    while (!done && cyc < 3000) begin
      in_valid_s[k]  = (idx < tw) ? ($urandom_range(99) < p_valid) : 1'b1;
      in_data_s[k]   = (idx < tw) ? beats[idx] : rand_beat();
      mem_ready_s[k] = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < p_ready);
      @(negedge clk);
      if (fin_exp) begin
        chk(k, "finish", finish_s[k], 1'b1);
        chk(k, "done_busy", busy_s[k], 1'b0);
        chk(k, "done_words_written", ww_s[k], 32'(tw));
        done = 1;
      end else begin
        exp_ready = (acc - wr < 2) && (acc < tw);
        exp_we    = (acc > wr);
        chk(k, "busy", busy_s[k], 1'b1);
        chk(k, "finish_early", finish_s[k], 1'b0);
        chk(k, "in_ready", in_ready_s[k], exp_ready);
        chk(k, "mem_we", mem_we_s[k], exp_we);
        chk(k, "words_written", ww_s[k], 32'(wr));
        if (exp_we) begin
          chk(k, "mem_addr", mem_addr_s[k], exp_addr(k, wr));
          chk(k, "mem_wdata", mem_wdata_s[k], exp_data(k, wr, beats[wr]));
          chk(k, "mem_lane_en", lane_s[k], exp_lanes(k, wr));
        end
        if (in_valid_s[k] && exp_ready) begin
          acc++;
          idx++;
        end
        if (exp_we && mem_ready_s[k]) begin
          wr++;
          if (wr == tw) fin_exp = 1;
        end
        if (stall_left > 0) stall_left--;
        if (stall && !stall_done && acc >= 2) begin
          stall_left = 5;
          stall_done = 1;
        end
        if (abort_after >= 0 && wr >= abort_after) aborting = 1;
      end
      @(posedge clk); #1;
      cyc++;
      if (aborting) begin
        reset = 1'b1;
        in_valid_s[k] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals(k);
        @(posedge clk); #1;
        done = 1;
      end
    end
    chk(k, "run_completed", done, 1'b1);

    if (!aborting) begin
      in_valid_s[k] = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk(k, "post_mem_we", mem_we_s[k], 1'b0);
      chk(k, "post_in_ready", in_ready_s[k], 1'b0);
      chk(k, "post_busy", busy_s[k], 1'b0);
      chk(k, "post_words_written", ww_s[k], 32'(tw));
      @(posedge clk); #1;
    end
    in_valid_s[k]  = 1'b0;
    mem_ready_s[k] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      in_valid_s[k] = 1'b0;
      mem_ready_s[k] = 1'b0;
      in_data_s[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_reset_vals(k);
    @(posedge clk); #1;

    run_vector(0, 100, 100, 1'b0, -1);
    run_vector(0, 60, 50, 1'b0, -1);
    run_vector(1, 100, 100, 1'b0, -1);
    run_vector(1, 50, 50, 1'b0, -1);
    run_vector(0, 100, 100, 1'b1, -1);
    run_vector(2, 70, 60, 1'b0, -1);
    run_vector(2, 100, 100, 1'b0, -1);
    run_vector(0, 100, 100, 1'b0, 10);
    run_vector(0, 100, 100, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
